// File: rtl/count_sequencer.sv
// count_sequencer
//   Sequencer for the stepped display counter. Owns the 8-bit count and
//   advances it by a configurable step on an internal tick enable derived
//   from a prescaler (no generated clock). Handles start/pause/single-step/
//   clear commands and step/limit configuration while idle.
//
//   Optional feature: define COUNT_SEQ_DOWN_EN to add the 'dir' input
//   (1 = count down). Without it the block counts up only.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      1-cycle pulse: run
//   pause      1-cycle pulse: pause
//   step_req   1-cycle pulse: single advance while paused
//   clear      1-cycle pulse: back to IDLE with count=0
//   wrap_mode  1 = wrap to 0 after limit, 0 = stop at limit (DONE)
//   cfg_load   1-cycle pulse: load cfg_step/cfg_limit (IDLE only)
//   cfg_step   step value
//   cfg_limit  terminal count value
//   dir        (COUNT_SEQ_DOWN_EN only) 1 = count down
//   cfg_ack    1-cycle pulse: configuration accepted
//   count      current count to the display decoder
//   count_upd  1-cycle pulse in the cycle count takes a new value
//   wrap       1-cycle pulse when count wraps at the terminal value
//   busy       1 while in RUN
//   state      IDLE=0 RUN=1 PAUSE=2 DONE=3
//
// State table
//   IDLE  | stopped, count=0, configuration accepted
//   RUN   | prescaler running, advances on every tick
//   PAUSE | prescaler frozen, step_req gives single advances
//   DONE  | stop-mode counter hit its terminal value, count held

module count_sequencer #(
    parameter int unsigned TICK_DIV  = 25_000_000,
    parameter logic [7:0]  DEF_STEP  = 8'd10,
    parameter logic [7:0]  DEF_LIMIT = 8'd150
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       pause,
    input  logic       step_req,
    input  logic       clear,
    input  logic       wrap_mode,
    input  logic       cfg_load,
    input  logic [7:0] cfg_step,
    input  logic [7:0] cfg_limit,
`ifdef COUNT_SEQ_DOWN_EN
    input  logic       dir,
`endif
    output logic       cfg_ack,
    output logic [7:0] count,
    output logic       count_upd,
    output logic       wrap,
    output logic       busy,
    output logic [1:0] state
);

    localparam int unsigned   PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        st;
    logic [7:0]    step_q;
    logic [7:0]    limit_q;
    logic [PW-1:0] prescaler;

    logic          tick;
    logic          do_adv;
    logic [7:0]    step_eff;
    logic [8:0]    sum;
    logic [7:0]    adv_count;
    logic          adv_wrap;
    logic          adv_done;
    logic [7:0]    restart_count;

    assign state = st;
    assign tick  = (st == ST_RUN) && (prescaler == PRE_LAST);

    // Next count for one advance step; the sum is 9 bits wide so an overflow
    // past 255 still compares correctly against the limit.
    always_comb begin
        step_eff      = (step_q == 8'd0) ? 8'd1 : step_q;
        sum           = {1'b0, count} + {1'b0, step_eff};
        adv_count     = count;
        adv_wrap      = 1'b0;
        adv_done      = 1'b0;
        restart_count = 8'd0;
        // pause outranks start, start outranks step_req; clear outranks all
        do_adv = !clear && !pause &&
                 ((st == ST_RUN && tick) ||
                  (st == ST_PAUSE && !start && step_req));
`ifdef COUNT_SEQ_DOWN_EN
        if (dir) begin
            restart_count = limit_q;
            if (count == 8'd0) begin
                if (wrap_mode) begin
                    adv_count = limit_q;
                    adv_wrap  = 1'b1;
                end else begin
                    adv_done  = 1'b1;
                end
            end else if (count < step_eff) begin
                adv_count = 8'd0;
            end else begin
                adv_count = count - step_eff;
            end
        end else
`endif
        begin
            if (count == limit_q) begin
                if (wrap_mode) begin
                    adv_count = 8'd0;
                    adv_wrap  = 1'b1;
                end else begin
                    adv_done  = 1'b1;
                end
            end else if (sum > {1'b0, limit_q}) begin
                adv_count = limit_q;
            end else begin
                adv_count = sum[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st        <= ST_IDLE;
            count     <= 8'd0;
            step_q    <= DEF_STEP;
            limit_q   <= DEF_LIMIT;
            prescaler <= '0;
            cfg_ack   <= 1'b0;
            count_upd <= 1'b0;
            wrap      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cfg_ack   <= 1'b0;
            count_upd <= 1'b0;
            wrap      <= 1'b0;

            if (st == ST_IDLE && cfg_load) begin
                step_q  <= cfg_step;
                limit_q <= cfg_limit;
                cfg_ack <= 1'b1;
            end

            if (clear) begin
                st        <= ST_IDLE;
                busy      <= 1'b0;
                prescaler <= '0;
                count     <= 8'd0;
                count_upd <= (count != 8'd0);
            end else begin
                case (st)
                    ST_IDLE, ST_PAUSE: begin
                        if (!pause && start) begin
                            st        <= ST_RUN;
                            busy      <= 1'b1;
                            prescaler <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (pause) begin
                            st   <= ST_PAUSE;
                            busy <= 1'b0;
                        end else if (tick) begin
                            prescaler <= '0;
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (!pause && start) begin
                            st        <= ST_RUN;
                            busy      <= 1'b1;
                            prescaler <= '0;
                            count     <= restart_count;
                            count_upd <= (restart_count != count);
                        end
                    end
                    default: st <= ST_IDLE;
                endcase

                if (do_adv) begin
                    count     <= adv_count;
                    count_upd <= (adv_count != count);
                    wrap      <= adv_wrap;
                    if (adv_done) begin
                        st   <= ST_DONE;
                        busy <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
